// File: rtl/mem_access_ctrl_if.sv
// ----------------------------------------------------------------------------
// mem_access_ctrl_if
//
// Data-memory request/acknowledge bus between the load/store sequencer and a
// (possibly slow or shared) data memory.
//
// Signals:
//   mem_req    sequencer -> memory  request, held high until ack or timeout
//   mem_we     sequencer -> memory  1 = write, valid with mem_req
//   mem_addr   sequencer -> memory  word-aligned byte address
//   mem_be     sequencer -> memory  byte enables, bit k = byte lane k
//   mem_wdata  sequencer -> memory  lane-replicated store data
//   mem_ack    memory -> sequencer  completion strobe
//   mem_rdata  memory -> sequencer  read word, valid with mem_ack
//
// Modports:
//   master  the sequencer side (drives the request)
//   slave   the memory side (drives the acknowledge)
// ----------------------------------------------------------------------------
interface mem_access_ctrl_if;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    modport master (
        output mem_req,
        output mem_we,
        output mem_addr,
        output mem_be,
        output mem_wdata,
        input  mem_ack,
        input  mem_rdata
    );

    modport slave (
        input  mem_req,
        input  mem_we,
        input  mem_addr,
        input  mem_be,
        input  mem_wdata,
        output mem_ack,
        output mem_rdata
    );
endinterface

// File: rtl/mem_access_ctrl.sv
// ----------------------------------------------------------------------------
// mem_access_ctrl
//
// Multi-cycle load/store sequencer between the execute stage and the data
// memory port. Forms ea = base + sext(offset), rejects misaligned accesses,
// runs a req/ack handshake with byte enables and lane-replicated write data,
// aborts after TIMEOUT unacknowledged request cycles, and returns the
// sign- or zero-extended load result.
//
// Parameters:
//   TIMEOUT      max request cycles without ack before abort (1..255)
//
// Ports:
//   clk          rising-edge clock
//   reset        synchronous active-high reset
//   start        operation request, accepted only when idle
//   store        1 = store, 0 = load
//   size         00 byte, 01 half, 10 word, 11 reserved (always misaligned)
//   unsigned_ld  loads: 1 = zero-extend, 0 = sign-extend
//   base         base register value
//   offset       16-bit immediate, sign-extended
//   wdata        store data, low bits significant
//   busy         high whenever not idle
//   done         one-cycle completion pulse
//   rdata        extended load result, 0 for stores and errors
//   err_misalign alignment error, valid with done
//   err_timeout  memory timeout, valid with done
//   mem          memory bus (master side)
// ----------------------------------------------------------------------------
module mem_access_ctrl #(
    parameter int TIMEOUT = 15
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic                     store,
    input  logic [1:0]               size,
    input  logic                     unsigned_ld,
    input  logic [31:0]              base,
    input  logic [15:0]              offset,
    input  logic [31:0]              wdata,
    output logic                     busy,
    output logic                     done,
    output logic [31:0]              rdata,
    output logic                     err_misalign,
    output logic                     err_timeout,
    mem_access_ctrl_if.master        mem
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Counter value seen in the last allowed request cycle.
    localparam logic [7:0] LAST_TICK = 8'(TIMEOUT - 1);

    state_t      state;
    state_t      next_state;

    logic [31:0] ea;
    logic        misalign;
    logic [3:0]  be_calc;
    logic [31:0] wdata_lanes;

    logic        store_r;
    logic [1:0]  size_r;
    logic        unsigned_r;
    logic [1:0]  ea_lo_r;
    logic [7:0]  tick_cnt;

    logic [31:0] addr_r;
    logic [3:0]  be_r;
    logic [31:0] wdata_r;
    logic [31:0] rdata_r;
    logic        err_misalign_r;
    logic        err_timeout_r;

    logic [7:0]  byte_lane;
    logic [15:0] half_lane;
    logic [31:0] load_ext;

    // Effective address wraps modulo 2^32; there is no overflow trap.
    assign ea = base + {{16{offset[15]}}, offset};

    // Alignment check on the incoming request; size 11 is never legal.
    always_comb begin
        misalign = 1'b0;
        case (size)
            2'b00:   misalign = 1'b0;
            2'b01:   misalign = ea[0];
            2'b10:   misalign = (ea[1:0] != 2'b00);
            default: misalign = 1'b1;
        endcase
    end

    // Byte enables and write-lane replication are decided at accept time
    // so the bus stays constant for the whole request.
    always_comb begin
        be_calc     = 4'b0000;
        wdata_lanes = wdata;
        case (size)
            2'b00: begin
                be_calc     = 4'b0001 << ea[1:0];
                wdata_lanes = {4{wdata[7:0]}};
            end
            2'b01: begin
                be_calc     = ea[1] ? 4'b1100 : 4'b0011;
                wdata_lanes = {2{wdata[15:0]}};
            end
            2'b10: begin
                be_calc     = 4'b1111;
                wdata_lanes = wdata;
            end
            default: begin
                be_calc     = 4'b0000;
                wdata_lanes = wdata;
            end
        endcase
    end

    // Pick the addressed lane out of the returned word and extend it.
    always_comb begin
        byte_lane = mem.mem_rdata[7:0];
        case (ea_lo_r)
            2'b00:   byte_lane = mem.mem_rdata[7:0];
            2'b01:   byte_lane = mem.mem_rdata[15:8];
            2'b10:   byte_lane = mem.mem_rdata[23:16];
            default: byte_lane = mem.mem_rdata[31:24];
        endcase
        half_lane = ea_lo_r[1] ? mem.mem_rdata[31:16] : mem.mem_rdata[15:0];
        case (size_r)
            2'b00:   load_ext = unsigned_r ? {24'h000000, byte_lane}
                                           : {{24{byte_lane[7]}}, byte_lane};
            2'b01:   load_ext = unsigned_r ? {16'h0000, half_lane}
                                           : {{16{half_lane[15]}}, half_lane};
            default: load_ext = mem.mem_rdata;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic. An ack in the final allowed cycle is checked before
    // the timeout so it wins.
    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (start) begin
                    next_state = misalign ? DONE : REQ;
                end
            end
            REQ: begin
                if (mem.mem_ack) begin
                    next_state = DONE;
                end else if (tick_cnt == LAST_TICK) begin
                    next_state = DONE;
                end
            end
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Datapath: latch the request on accept, count unacknowledged request
    // cycles, and capture the result. rdata and the error flags are cleared
    // only when the next operation is accepted.
    always_ff @(posedge clk) begin
        if (reset) begin
            store_r        <= 1'b0;
            size_r         <= 2'b00;
            unsigned_r     <= 1'b0;
            ea_lo_r        <= 2'b00;
            tick_cnt       <= 8'h00;
            addr_r         <= 32'h0;
            be_r           <= 4'h0;
            wdata_r        <= 32'h0;
            rdata_r        <= 32'h0;
            err_misalign_r <= 1'b0;
            err_timeout_r  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        store_r        <= store;
                        size_r         <= size;
                        unsigned_r     <= unsigned_ld;
                        ea_lo_r        <= ea[1:0];
                        tick_cnt       <= 8'h00;
                        addr_r         <= {ea[31:2], 2'b00};
                        be_r           <= be_calc;
                        wdata_r        <= wdata_lanes;
                        rdata_r        <= 32'h0;
                        err_misalign_r <= misalign;
                        err_timeout_r  <= 1'b0;
                    end
                end
                REQ: begin
                    if (mem.mem_ack) begin
                        rdata_r <= store_r ? 32'h0 : load_ext;
                    end else begin
                        tick_cnt <= tick_cnt + 8'h01;
                        if (tick_cnt == LAST_TICK) begin
                            err_timeout_r <= 1'b1;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign busy          = (state != IDLE);
    assign done          = (state == DONE);
    assign rdata         = rdata_r;
    assign err_misalign  = err_misalign_r;
    assign err_timeout   = err_timeout_r;

    assign mem.mem_req   = (state == REQ);
    assign mem.mem_we    = (state == REQ) && store_r;
    assign mem.mem_addr  = addr_r;
    assign mem.mem_be    = be_r;
    assign mem.mem_wdata = wdata_r;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// ----------------------------------------------------------------------------
// tb_mem_access_ctrl
//
// Directed self-checking bench for mem_access_ctrl with TIMEOUT = 4. The
// bench plays the memory by driving mem_ack/mem_rdata directly. Inputs are
// changed 1 ns after the rising edge and outputs are sampled at that point.
// ----------------------------------------------------------------------------
module tb_mem_access_ctrl;

    logic        clk;
    logic        reset;
    logic        start;
    logic        store;
    logic [1:0]  size;
    logic        unsigned_ld;
    logic [31:0] base;
    logic [15:0] offset;
    logic [31:0] wdata;
    logic        busy;
    logic        done;
    logic [31:0] rdata;
    logic        err_misalign;
    logic        err_timeout;

    int passes = 0;
    int total  = 0;
    int fails  = 0;

    mem_access_ctrl_if mem_bus ();

    mem_access_ctrl #(.TIMEOUT(4)) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .store        (store),
        .size         (size),
        .unsigned_ld  (unsigned_ld),
        .base         (base),
        .offset       (offset),
        .wdata        (wdata),
        .busy         (busy),
        .done         (done),
        .rdata        (rdata),
        .err_misalign (err_misalign),
        .err_timeout  (err_timeout),
        .mem          (mem_bus.master)
    );

    // 10 ns clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Advance one cycle and settle just after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs,
                               input logic [31:0] exp);
        total++;
        assert (obs === exp) begin
            passes++;
        end else begin
            fails++;
            $error("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Present one request for a single edge; returns in cycle 1.
    task automatic applyStimulus(input logic st, input logic [1:0] sz,
                                 input logic uns, input logic [31:0] b,
                                 input logic [15:0] off, input logic [31:0] wd);
        store       = st;
        size        = sz;
        unsigned_ld = uns;
        base        = b;
        offset      = off;
        wdata       = wd;
        start       = 1'b1;
        step();
        start       = 1'b0;
    endtask

    // Single-cycle ack in the current cycle; returns in the done cycle.
    task automatic ackNow(input logic [31:0] word);
        mem_bus.mem_ack   = 1'b1;
        mem_bus.mem_rdata = word;
        step();
        mem_bus.mem_ack   = 1'b0;
        mem_bus.mem_rdata = 32'h0;
    endtask

    initial begin
        int req_cycles;
        int guard;
        int done_seen;

        reset             = 1'b1;
        start             = 1'b0;
        store             = 1'b0;
        size              = 2'b00;
        unsigned_ld       = 1'b0;
        base              = 32'h0;
        offset            = 16'h0;
        wdata             = 32'h0;
        mem_bus.mem_ack   = 1'b0;
        mem_bus.mem_rdata = 32'h0;
        step();
        step();

        $display("[TB] reset values");
        checkOutput("rst_busy",  32'(busy),             32'h0);
        checkOutput("rst_req",   32'(mem_bus.mem_req),  32'h0);
        checkOutput("rst_we",    32'(mem_bus.mem_we),   32'h0);
        checkOutput("rst_done",  32'(done),             32'h0);
        checkOutput("rst_addr",  mem_bus.mem_addr,      32'h0);
        checkOutput("rst_be",    32'(mem_bus.mem_be),   32'h0);
        checkOutput("rst_wdata", mem_bus.mem_wdata,     32'h0);
        checkOutput("rst_rdata", rdata,                 32'h0);
        checkOutput("rst_errs",  32'({err_misalign, err_timeout}), 32'h0);
        reset = 1'b0;
        step();

        $display("[TB] LW with ack in third request cycle");
        applyStimulus(1'b0, 2'b10, 1'b0, 32'h0000_1000, 16'hFFFC, 32'h0);
        checkOutput("lw_c1_req",  32'(mem_bus.mem_req), 32'h1);
        checkOutput("lw_c1_busy", 32'(busy),            32'h1);
        checkOutput("lw_addr",    mem_bus.mem_addr,     32'h0000_0FFC);
        checkOutput("lw_be",      32'(mem_bus.mem_be),  32'hF);
        checkOutput("lw_we",      32'(mem_bus.mem_we),  32'h0);
        step();
        checkOutput("lw_c2_req",  32'(mem_bus.mem_req), 32'h1);
        step();
        checkOutput("lw_c3_req",  32'(mem_bus.mem_req), 32'h1);
        checkOutput("lw_c3_done", 32'(done),            32'h0);
        checkOutput("lw_c3_addr", mem_bus.mem_addr,     32'h0000_0FFC);
        ackNow(32'hDEAD_BEEF);
        checkOutput("lw_done",    32'(done),            32'h1);
        checkOutput("lw_req_off", 32'(mem_bus.mem_req), 32'h0);
        checkOutput("lw_rdata",   rdata,                32'hDEAD_BEEF);
        checkOutput("lw_errs",    32'({err_misalign, err_timeout}), 32'h0);
        step();
        checkOutput("lw_idle",    32'(busy),            32'h0);
        checkOutput("lw_pulse",   32'(done),            32'h0);
        checkOutput("lw_hold",    rdata,                32'hDEAD_BEEF);

        $display("[TB] LB vs LBU on lane 3");
        applyStimulus(1'b0, 2'b00, 1'b0, 32'h0000_2000, 16'h0003, 32'h0);
        checkOutput("lb_be",    32'(mem_bus.mem_be), 32'h8);
        checkOutput("lb_addr",  mem_bus.mem_addr,    32'h0000_2000);
        ackNow(32'h8000_0000);
        checkOutput("lb_done",  32'(done),           32'h1);
        checkOutput("lb_rdata", rdata,               32'hFFFF_FF80);
        step();
        applyStimulus(1'b0, 2'b00, 1'b1, 32'h0000_2000, 16'h0003, 32'h0);
        checkOutput("lbu_rst_rdata", rdata,          32'h0);
        ackNow(32'h8000_0000);
        checkOutput("lbu_rdata", rdata,              32'h0000_0080);
        step();

        $display("[TB] LH signed from upper half");
        applyStimulus(1'b0, 2'b01, 1'b0, 32'h0000_3000, 16'h0002, 32'h0);
        checkOutput("lh_be",    32'(mem_bus.mem_be), 32'hC);
        ackNow(32'h9ABC_1234);
        checkOutput("lh_rdata", rdata,               32'hFFFF_9ABC);
        step();

        $display("[TB] SH to upper half");
        applyStimulus(1'b1, 2'b01, 1'b0, 32'h0000_0010, 16'h0002, 32'h1234_ABCD);
        checkOutput("sh_addr",  mem_bus.mem_addr,    32'h0000_0010);
        checkOutput("sh_be",    32'(mem_bus.mem_be), 32'hC);
        checkOutput("sh_we",    32'(mem_bus.mem_we), 32'h1);
        checkOutput("sh_wdata", mem_bus.mem_wdata,   32'hABCD_ABCD);
        ackNow(32'hFFFF_FFFF);
        checkOutput("sh_done",  32'(done),           32'h1);
        checkOutput("sh_rdata", rdata,               32'h0);
        step();

        $display("[TB] SB lane 1 replication");
        applyStimulus(1'b1, 2'b00, 1'b0, 32'h0000_0040, 16'h0001, 32'h0000_00A5);
        checkOutput("sb_be",    32'(mem_bus.mem_be), 32'h2);
        checkOutput("sb_wdata", mem_bus.mem_wdata,   32'hA5A5_A5A5);
        ackNow(32'h0);
        step();

        $display("[TB] address wrap");
        applyStimulus(1'b0, 2'b10, 1'b0, 32'hFFFF_FFFC, 16'h0004, 32'h0);
        checkOutput("wrap_addr", mem_bus.mem_addr,   32'h0000_0000);
        checkOutput("wrap_req",  32'(mem_bus.mem_req), 32'h1);
        ackNow(32'h0000_0001);
        checkOutput("wrap_rdata", rdata,             32'h0000_0001);
        step();

        $display("[TB] misaligned LW and reserved size");
        applyStimulus(1'b0, 2'b10, 1'b0, 32'h0000_1001, 16'h0000, 32'h0);
        checkOutput("mis_req",  32'(mem_bus.mem_req), 32'h0);
        checkOutput("mis_done", 32'(done),            32'h1);
        checkOutput("mis_err",  32'(err_misalign),    32'h1);
        checkOutput("mis_rdata", rdata,               32'h0);
        step();
        checkOutput("mis_idle", 32'(busy),            32'h0);
        checkOutput("mis_hold", 32'(err_misalign),    32'h1);
        applyStimulus(1'b0, 2'b11, 1'b0, 32'h0000_1000, 16'h0000, 32'h0);
        checkOutput("rsv_req",  32'(mem_bus.mem_req), 32'h0);
        checkOutput("rsv_done", 32'(done),            32'h1);
        checkOutput("rsv_err",  32'(err_misalign),    32'h1);
        step();
        applyStimulus(1'b0, 2'b01, 1'b0, 32'h0000_1001, 16'h0000, 32'h0);
        checkOutput("mish_err", 32'(err_misalign),    32'h1);
        step();

        $display("[TB] timeout with no ack");
        applyStimulus(1'b0, 2'b10, 1'b0, 32'h0000_0100, 16'h0000, 32'h0);
        req_cycles = 0;
        guard      = 0;
        while (!done && guard < 20) begin
            if (mem_bus.mem_req) req_cycles++;
            step();
            guard++;
        end
        checkOutput("to_done",   32'(done),           32'h1);
        checkOutput("to_cycles", 32'(req_cycles),     32'd4);
        checkOutput("to_err",    32'(err_timeout),    32'h1);
        checkOutput("to_req",    32'(mem_bus.mem_req), 32'h0);
        checkOutput("to_rdata",  rdata,               32'h0);
        step();
        checkOutput("to_idle",   32'(busy),           32'h0);

        $display("[TB] ack in last allowed cycle");
        applyStimulus(1'b0, 2'b10, 1'b0, 32'h0000_0100, 16'h0000, 32'h0);
        checkOutput("tl_err_clr", 32'(err_timeout),   32'h0);
        step();
        step();
        step();
        checkOutput("tl_c4_req", 32'(mem_bus.mem_req), 32'h1);
        ackNow(32'h55AA_1234);
        checkOutput("tl_done",   32'(done),           32'h1);
        checkOutput("tl_err",    32'(err_timeout),    32'h0);
        checkOutput("tl_rdata",  rdata,               32'h55AA_1234);
        step();

        $display("[TB] reset during request");
        applyStimulus(1'b0, 2'b10, 1'b0, 32'h0000_0200, 16'h0000, 32'h0);
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        checkOutput("rr_req",  32'(mem_bus.mem_req),  32'h0);
        checkOutput("rr_busy", 32'(busy),             32'h0);
        mem_bus.mem_ack   = 1'b1;
        mem_bus.mem_rdata = 32'h1111_1111;
        done_seen = 0;
        for (int i = 0; i < 3; i++) begin
            step();
            if (done) done_seen++;
        end
        mem_bus.mem_ack   = 1'b0;
        mem_bus.mem_rdata = 32'h0;
        checkOutput("rr_no_done", 32'(done_seen),     32'd0);
        checkOutput("rr_rdata",   rdata,              32'h0);

        $display("[TB] start ignored during request");
        applyStimulus(1'b0, 2'b10, 1'b0, 32'h0000_0300, 16'h0000, 32'h0);
        base  = 32'h0000_0700;
        start = 1'b1;
        step();
        checkOutput("ig_addr", mem_bus.mem_addr,      32'h0000_0300);
        step();
        start = 1'b0;
        ackNow(32'h0000_0ABC);
        checkOutput("ig_done",  32'(done),            32'h1);
        checkOutput("ig_rdata", rdata,                32'h0000_0ABC);
        done_seen = 0;
        for (int i = 0; i < 3; i++) begin
            step();
            if (done || busy) done_seen++;
        end
        checkOutput("ig_no_extra", 32'(done_seen),    32'd0);

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end

    // Global safety net in case the stimulus sequence stalls.
    initial begin
        #100000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
